// File: rtl/artemis_ddr3_pkg.sv
// Shared definitions for the Artemis DDR3 port arbiter.
//   - MCB command instruction codes
//   - arbiter FSM state encoding
//   - hard ceiling on MCB burst length (words)
package artemis_ddr3_pkg;

  localparam logic [2:0] MCB_WR    = 3'b000;
  localparam logic [2:0] MCB_RD    = 3'b001;
  localparam logic [2:0] MCB_WR_AP = 3'b010;
  localparam logic [2:0] MCB_RD_AP = 3'b011;
  localparam logic [2:0] MCB_REF   = 3'b100;

  localparam int MCB_MAX_BL = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
    S_WR_DATA,
    S_WR_CMD,
    S_RD_CMD,
    S_RD_DATA,
    S_DONE
  } state_t;

endpackage

// File: rtl/artemis_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot winner (zero when nothing requests)
//   idx   : binary index of the winner
module artemis_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    int c;
    idx = '0;
    // Scan from the far end back towards ptr so the requester closest
    // to ptr is the last (winning) assignment.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (req[IDX_W'(c)]) idx = IDX_W'(c);
    end
    grant = (|req) ? (NUM_CH'(1) << idx) : '0;
  end

endmodule

// File: rtl/artemis_ddr3_port_arbiter.sv
// Multi-channel front end for one Spartan-6 MCB user port.
// Round-robin arbitration of NUM_CH clients; each client transfer is cut
// into MCB bursts of at most MAX_BL words, one burst in flight at a time.
// Writes: data is pushed first, then the write command. Reads: command
// first, then bl words are popped to the client.
//   clk/rst_n          : clock, async active-low reset
//   calib_done         : gates new grants only
//   ch_req/wr/addr/len : client request, sampled at grant
//   ch_grant/ch_done   : grant level / end-of-transfer pulse
//   ch_w*, ch_r*       : per-client write / read streams
//   cmd_*, wr_*, rd_*  : MCB cmd / write / read FIFO ports
//   busy, error        : status; error is sticky on underrun/overflow
// Build option: ARTEMIS_DDR3_ARB_PRIORITY_EN gives channel 0 fixed top
// priority; the round-robin pointer then rotates over channels 1..N-1.
module artemis_ddr3_port_arbiter
  import artemis_ddr3_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 16,
  parameter int MAX_BL = 32,
  parameter int ADDR_W = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     calib_done,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic [NUM_CH-1:0]        ch_done,
  input  logic [NUM_CH-1:0]        ch_wvalid,
  input  logic [NUM_CH*32-1:0]     ch_wdata,
  input  logic [NUM_CH*4-1:0]      ch_wmask,
  output logic [NUM_CH-1:0]        ch_wready,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [31:0]              ch_rdata,
  input  logic [NUM_CH-1:0]        ch_rready,
  output logic                     cmd_en,
  output logic [2:0]               cmd_instr,
  output logic [5:0]               cmd_bl,
  output logic [ADDR_W-1:0]        cmd_byte_addr,
  input  logic                     cmd_full,
  output logic                     wr_en,
  output logic [31:0]              wr_data,
  output logic [3:0]               wr_mask,
  input  logic                     wr_full,
  input  logic                     wr_underrun,
  output logic                     rd_en,
  input  logic [31:0]              rd_data,
  input  logic                     rd_empty,
  input  logic                     rd_overflow,
  output logic                     busy,
  output logic                     error
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BL_W  = $clog2(MCB_MAX_BL) + 1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
  } xfer_t;

  logic [NUM_CH-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_CH-1:0][LEN_W-1:0]  len_v;
  logic [NUM_CH-1:0][31:0]       wdata_v;
  logic [NUM_CH-1:0][3:0]        wmask_v;
  assign addr_v  = ch_addr;
  assign len_v   = ch_len;
  assign wdata_v = ch_wdata;
  assign wmask_v = ch_wmask;

  state_t            state, state_nx;
  xfer_t             xf;
  logic [IDX_W-1:0]  gidx, ptr;
  logic [BL_W-1:0]   bl, cnt;
  logic              err_q;
  logic              wr_fire, rd_fire, cmd_fire, adv, last_burst, burst_end;

  // ---------------- arbitration ----------------
  logic [NUM_CH-1:0] rr_req, rr_grant;
  logic [IDX_W-1:0]  rr_idx, rr_next, win_idx, ptr_nx;
  logic              win_any;

  artemis_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
    .req   (rr_req),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  assign rr_next = (int'(rr_idx) == NUM_CH - 1) ? '0 : rr_idx + 1'b1;

`ifdef ARTEMIS_DDR3_ARB_PRIORITY_EN
  // Channel 0 bypasses the rotation and leaves the pointer untouched.
  assign rr_req  = ch_req & ~NUM_CH'(1);
  assign win_any = ch_req[0] | (|rr_grant);
  assign win_idx = ch_req[0] ? '0 : rr_idx;
  assign ptr_nx  = ch_req[0] ? ptr : rr_next;
`else
  assign rr_req  = ch_req;
  assign win_any = |rr_grant;
  assign win_idx = rr_idx;
  assign ptr_nx  = rr_next;
`endif

  // ---------------- FSM ----------------
  assign last_burst = (xf.rem == LEN_W'(bl));
  assign burst_end  = (cnt == bl - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    ch_grant      = '0;
    ch_done       = '0;
    ch_wready     = '0;
    ch_rvalid     = '0;
    ch_rdata      = '0;
    cmd_en        = 1'b0;
    cmd_instr     = MCB_WR;
    cmd_bl        = '0;
    cmd_byte_addr = '0;
    wr_en         = 1'b0;
    wr_data       = '0;
    wr_mask       = '0;
    rd_en         = 1'b0;
    wr_fire       = 1'b0;
    rd_fire       = 1'b0;
    cmd_fire      = 1'b0;
    adv           = 1'b0;
    if (state != S_IDLE && state != S_DONE) ch_grant[gidx] = 1'b1;
    case (state)
      S_IDLE:
        if (calib_done && win_any) state_nx = S_BURST;
      S_BURST:
        // rem is only zero here for a zero-length request
        if (xf.rem == '0) state_nx = S_DONE;
        else              state_nx = xf.wr ? S_WR_DATA : S_RD_CMD;
      S_WR_DATA: begin
        ch_wready[gidx] = !wr_full;
        wr_fire         = ch_wvalid[gidx] & !wr_full;
        wr_en           = wr_fire;
        wr_data         = wdata_v[gidx];
        wr_mask         = wmask_v[gidx];
        if (wr_fire && burst_end) state_nx = S_WR_CMD;
      end
      S_WR_CMD, S_RD_CMD: begin
        // cmd_en is held while the FIFO is full; the command is taken
        // on the first cycle with cmd_full low.
        cmd_en        = 1'b1;
        cmd_instr     = (state == S_WR_CMD) ? MCB_WR : MCB_RD;
        cmd_bl        = 6'(bl - 1'b1);
        cmd_byte_addr = xf.addr;
        cmd_fire      = !cmd_full;
        if (cmd_fire) begin
          if (state == S_RD_CMD) state_nx = S_RD_DATA;
          else begin
            adv      = 1'b1;
            state_nx = last_burst ? S_DONE : S_BURST;
          end
        end
      end
      S_RD_DATA: begin
        ch_rvalid[gidx] = !rd_empty;
        rd_fire         = !rd_empty & ch_rready[gidx];
        rd_en           = rd_fire;
        ch_rdata        = rd_data;
        if (rd_fire && burst_end) begin
          adv      = 1'b1;
          state_nx = last_burst ? S_DONE : S_BURST;
        end
      end
      S_DONE: begin
        ch_done[gidx] = 1'b1;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xf    <= '0;
      gidx  <= '0;
      ptr   <= '0;
      bl    <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | wr_underrun | rd_overflow;
      if (state == S_IDLE && calib_done && win_any) begin
        gidx    <= win_idx;
        ptr     <= ptr_nx;
        xf.wr   <= ch_wr[win_idx];
        xf.addr <= addr_v[win_idx];
        xf.rem  <= len_v[win_idx];
      end
      if (state == S_BURST) begin
        bl  <= (int'(xf.rem) > MAX_BL) ? BL_W'(MAX_BL) : BL_W'(xf.rem);
        cnt <= '0;
      end
      if (wr_fire || rd_fire) cnt <= cnt + 1'b1;
      if (adv) begin
        xf.addr <= xf.addr + (ADDR_W'(bl) << 2);
        xf.rem  <= xf.rem - LEN_W'(bl);
      end
    end
  end

  assign busy  = (state != S_IDLE);
  assign error = err_q;

endmodule
